// File: rtl/gps_baseband_gen.sv
`timescale 1ns/1ps
// gps_baseband_gen: synthetic GPS L1 C/A baseband sample source for tracking-loop bring-up
module gps_baseband_gen #(
  parameter int PHASE_W = 32,
  parameter int MS_PER_BIT = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               start,
  input  logic [4:0]         prn,
  input  logic [9:0]         code_phase_init,
  input  logic [PHASE_W-1:0] code_freq,
  input  logic [PHASE_W-1:0] carrier_freq,
  input  logic               nav_bit,
  output logic [2:0]         baseband,
  output logic               valid,
  output logic               busy,
  output logic               code_start,
  output logic [4:0]         ms_count
);
  localparam logic [1:0] IDLE = 2'd0, SLEW = 2'd1, RUN = 2'd2;
  logic [1:0] state;
  logic [4:0] prn_q;
  logic [10:1] g1, g2, g1_nx, g2_nx;
  logic [9:0] idx, slew, off;
  logic [PHASE_W-1:0] code_acc, carr_acc;
  logic [PHASE_W:0] code_sum;
  logic [3:0] ta, tb;
  logic [2:0] oct;
  logic [1:0] mag;
  logic data, chip, sign, carry, wrap, last;
  // G2 output tap pair for the latched satellite (IS-GPS-200 code phase assignments)
  always_comb begin
    {ta, tb} = 8'h26;
    case (prn_q)
      5'd0:  {ta, tb} = 8'h26;
      5'd1:  {ta, tb} = 8'h37;
      5'd2:  {ta, tb} = 8'h48;
      5'd3:  {ta, tb} = 8'h59;
      5'd4:  {ta, tb} = 8'h19;
      5'd5:  {ta, tb} = 8'h2A;
      5'd6:  {ta, tb} = 8'h18;
      5'd7:  {ta, tb} = 8'h29;
      5'd8:  {ta, tb} = 8'h3A;
      5'd9:  {ta, tb} = 8'h23;
      5'd10: {ta, tb} = 8'h34;
      5'd11: {ta, tb} = 8'h56;
      5'd12: {ta, tb} = 8'h67;
      5'd13: {ta, tb} = 8'h78;
      5'd14: {ta, tb} = 8'h89;
      5'd15: {ta, tb} = 8'h9A;
      5'd16: {ta, tb} = 8'h14;
      5'd17: {ta, tb} = 8'h25;
      5'd18: {ta, tb} = 8'h36;
      5'd19: {ta, tb} = 8'h47;
      5'd20: {ta, tb} = 8'h58;
      5'd21: {ta, tb} = 8'h69;
      5'd22: {ta, tb} = 8'h13;
      5'd23: {ta, tb} = 8'h46;
      5'd24: {ta, tb} = 8'h57;
      5'd25: {ta, tb} = 8'h68;
      5'd26: {ta, tb} = 8'h79;
      5'd27: {ta, tb} = 8'h8A;
      5'd28: {ta, tb} = 8'h16;
      5'd29: {ta, tb} = 8'h27;
      5'd30: {ta, tb} = 8'h38;
      5'd31: {ta, tb} = 8'h49;
    endcase
  end
  // next LFSR states, code carry/wrap, chip and carrier octant mapping
  always_comb begin
    g1_nx = {g1[9:1], g1[3] ^ g1[10]};
    g2_nx = {g2[9:1], g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10]};
    code_sum = {1'b0, code_acc} + {1'b0, code_freq};
    carry = code_sum[PHASE_W];
    wrap = carry && idx == 10'd1022;
    last = ms_count == 5'(MS_PER_BIT - 1);
    chip = g1[10] ^ g2[ta] ^ g2[tb];
    oct = carr_acc[PHASE_W-1 -: 3];
    mag = {~(oct[1] ^ oct[0]), 1'b1};
    sign = chip ^ data ^ oct[2] ^ oct[1];
    off = code_phase_init > 10'd1022 ? 10'd1022 : code_phase_init;
  end
  // FSM, code generators, NCOs and registered outputs; everything holds while enable is low
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      prn_q <= '0;
      g1 <= '1;
      g2 <= '1;
      idx <= '0;
      slew <= '0;
      code_acc <= '0;
      carr_acc <= '0;
      ms_count <= '0;
      data <= 1'b0;
      baseband <= '0;
      valid <= 1'b0;
      busy <= 1'b0;
      code_start <= 1'b0;
    end else if (!enable)
      code_start <= 1'b0;
    else begin
      baseband <= state == RUN ? {sign, mag} : 3'b000;
      valid <= state == RUN;
      busy <= state == SLEW;
      code_start <= state == RUN && wrap && !start;
      if (start) begin
        prn_q <= prn;
        slew <= off;
        g1 <= '1;
        g2 <= '1;
        idx <= '0;
        code_acc <= '0;
        carr_acc <= '0;
        ms_count <= '0;
        data <= nav_bit;
        state <= off == 10'd0 ? RUN : SLEW;
      end else if (state == SLEW) begin
        g1 <= g1_nx;
        g2 <= g2_nx;
        idx <= idx + 10'd1;
        slew <= slew - 10'd1;
        if (slew == 10'd1) state <= RUN;
      end else if (state == RUN) begin
        code_acc <= code_sum[PHASE_W-1:0];
        carr_acc <= carr_acc + carrier_freq;
        if (wrap) begin
          g1 <= '1;
          g2 <= '1;
          idx <= '0;
          ms_count <= last ? 5'd0 : ms_count + 5'd1;
          if (last) data <= nav_bit;
        end else if (carry) begin
          g1 <= g1_nx;
          g2 <= g2_nx;
          idx <= idx + 10'd1;
        end
      end
    end
endmodule
